// File: rtl/fb_game_writer.sv
// Frame-buffer write-side game FSM: clears the buffer after reset, then moves a cursor cell on debounced button presses.
// Optional feature macro FB_WRITER_COLOR_CYCLE_EN: both buttons together cycle the cursor colour instead of being ignored.
module fb_game_writer #(
    parameter int            AW         = 4,
    parameter int            DW         = 3,
    parameter int            CELLS      = 16,
    parameter int            DEB_CYCLES = 250000,
    parameter logic [DW-1:0] BG_COLOR   = 3'b000,
    parameter logic [DW-1:0] FG_COLOR   = 3'b100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_r,
    input  logic          btn_l,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          busy,
    output logic [AW-1:0] cursor_pos
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int IW = AW + 1;

    typedef enum logic [1:0] {CLEAR, IDLE, ERASE, DRAW} state_t;

    // Index 0 is the right button, index 1 the left button.
    logic [1:0]    btn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    press;
    logic          pr;
    logic          pl;

    assign btn   = {btn_l, btn_r};
    assign press = deb & ~deb_d;
    assign pr    = press[0];
    assign pl    = press[1];

    // The debounced level only follows the synchronised input after an unbroken run of DEB_CYCLES differing samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [AW-1:0] new_pos, new_n;
    logic [AW-1:0] pos_n;
    logic [DW-1:0] color, color_n;
    logic          wr_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] data_n;
    logic          busy_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= CLEAR;
            idx         <= '0;
            new_pos     <= '0;
            cursor_pos  <= '0;
            color       <= FG_COLOR;
            px_wr       <= 1'b0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            busy        <= 1'b1;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            new_pos     <= new_n;
            cursor_pos  <= pos_n;
            color       <= color_n;
            px_wr       <= wr_n;
            mem_px_addr <= addr_n;
            mem_px_data <= data_n;
            busy        <= busy_n;
        end
    end

    // The state names the write currently on the bus; each branch registers the write of the following cycle.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        new_n   = new_pos;
        pos_n   = cursor_pos;
        color_n = color;
        wr_n    = 1'b0;
        addr_n  = mem_px_addr;
        data_n  = mem_px_data;
        busy_n  = 1'b1;
        case (state)
            CLEAR: begin
                wr_n = 1'b1;
                if (idx == IW'(CELLS)) begin
                    // Every cell is background now; paint the cursor at cell 0.
                    addr_n  = '0;
                    data_n  = color;
                    new_n   = '0;
                    pos_n   = '0;
                    idx_n   = '0;
                    state_n = DRAW;
                end else begin
                    addr_n = idx[AW-1:0];
                    data_n = BG_COLOR;
                    idx_n  = idx + IW'(1);
                end
            end
            IDLE: begin
                busy_n = 1'b0;
                if (pr && !pl) begin
                    new_n   = (cursor_pos == AW'(CELLS - 1)) ? '0 : cursor_pos + AW'(1);
                    wr_n    = 1'b1;
                    addr_n  = cursor_pos;
                    data_n  = BG_COLOR;
                    busy_n  = 1'b1;
                    state_n = ERASE;
                end else if (pl && !pr) begin
                    new_n   = (cursor_pos == '0) ? AW'(CELLS - 1) : cursor_pos - AW'(1);
                    wr_n    = 1'b1;
                    addr_n  = cursor_pos;
                    data_n  = BG_COLOR;
                    busy_n  = 1'b1;
                    state_n = ERASE;
                end else if (pr && pl) begin
`ifdef FB_WRITER_COLOR_CYCLE_EN
                    // Repaint in place with the rotated colour; nothing to erase.
                    color_n = (color == '0) ? FG_COLOR : {color[0], color[DW-1:1]};
                    new_n   = cursor_pos;
                    wr_n    = 1'b1;
                    addr_n  = cursor_pos;
                    data_n  = color_n;
                    busy_n  = 1'b1;
                    state_n = DRAW;
`else
                    state_n = IDLE;
`endif
                end
            end
            ERASE: begin
                wr_n    = 1'b1;
                addr_n  = new_pos;
                data_n  = color;
                pos_n   = new_pos;
                state_n = DRAW;
            end
            DRAW: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = CLEAR;
                idx_n   = '0;
            end
        endcase
    end

endmodule
